// File: rtl/dsp_adder_arbiter_if.sv
// rtl/dsp_adder_arbiter_if.sv - requester, result and DSP-side signals of the shared adder arbiter
interface dsp_adder_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic             addsub0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic             addsub1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] result;
    logic             result_zero;
    logic             busy;
    logic [WIDTH-1:0] dsp_in1;
    logic [WIDTH-1:0] dsp_in2;
    logic             dsp_addsub;
    logic [WIDTH-1:0] dsp_out;

    modport master (
        output req0, addsub0, a0, b0, req1, addsub1, a1, b1, dsp_out,
        input  ack0, ack1, result, result_zero, busy, dsp_in1, dsp_in2, dsp_addsub
    );

    modport slave (
        input  req0, addsub0, a0, b0, req1, addsub1, a1, b1, dsp_out,
        output ack0, ack1, result, result_zero, busy, dsp_in1, dsp_in2, dsp_addsub
    );
endinterface

// File: rtl/dsp_adder_arbiter.sv
// rtl/dsp_adder_arbiter.sv - shares one adder_dsp add/sub between two requesters, one op per 3 cycles
// Define DSP_ARB_FIXED_PRIORITY_EN to give requester 0 every tie instead of round robin.
module dsp_adder_arbiter #(
    parameter int WIDTH = 32
) (
    input logic                 clk,
    input logic                 reset,
    dsp_adder_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_grant_valid;
    logic             w_winner;
    logic             r_owner;
    logic [WIDTH-1:0] r_dsp_in1;
    logic [WIDTH-1:0] r_dsp_in2;
    logic             r_dsp_addsub;
    logic [WIDTH-1:0] r_result;
    logic             r_result_zero;
    logic             r_ack0;
    logic             r_ack1;
`ifndef DSP_ARB_FIXED_PRIORITY_EN
    logic             r_last_grant;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_winner      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_grant_valid = 1'b1;
                    w_next_state  = S_ISSUE;
`ifdef DSP_ARB_FIXED_PRIORITY_EN
                    w_winner = !bus.req0;
`else
                    // On a tie the requester that did not win last time goes next
                    w_winner = (bus.req0 && bus.req1) ? !r_last_grant : !bus.req0;
`endif
                end
            end
            S_ISSUE: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner       <= 1'b0;
            r_dsp_in1     <= '0;
            r_dsp_in2     <= '0;
            r_dsp_addsub  <= 1'b0;
            r_result      <= '0;
            r_result_zero <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
`ifndef DSP_ARB_FIXED_PRIORITY_EN
            r_last_grant  <= 1'b1;
`endif
        end else begin
            if (w_grant_valid) begin
                r_owner      <= w_winner;
                r_dsp_in1    <= w_winner ? bus.a1 : bus.a0;
                r_dsp_in2    <= w_winner ? bus.b1 : bus.b0;
                r_dsp_addsub <= w_winner ? bus.addsub1 : bus.addsub0;
`ifndef DSP_ARB_FIXED_PRIORITY_EN
                r_last_grant <= w_winner;
`endif
            end
            // DSP inputs have been stable for the full ISSUE cycle, so dsp_out is settled here
            if (r_state == S_ISSUE) begin
                r_result      <= bus.dsp_out;
                r_result_zero <= (bus.dsp_out == '0);
                r_ack0        <= !r_owner;
                r_ack1        <= r_owner;
            end
            if (r_state == S_DONE) begin
                r_ack0 <= 1'b0;
                r_ack1 <= 1'b0;
            end
        end
    end

    assign bus.ack0        = r_ack0;
    assign bus.ack1        = r_ack1;
    assign bus.result      = r_result;
    assign bus.result_zero = r_result_zero;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.dsp_in1     = r_dsp_in1;
    assign bus.dsp_in2     = r_dsp_in2;
    assign bus.dsp_addsub  = r_dsp_addsub;
endmodule

// File: tb/tb_dsp_adder_arbiter.sv
// tb/tb_dsp_adder_arbiter.sv - randomized scoreboard bench for dsp_adder_arbiter
module tb_dsp_adder_arbiter;
    typedef struct {
        bit          owner;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;
    bit   zero_chk;
    bit   skip_busy;
    bit   done;
    exp_t exp_q[$];

    bit          pend[2];
    logic [31:0] pa[2];
    logic [31:0] pb[2];
    bit          ps[2];
    int          last;

    dsp_adder_arbiter_if #(.WIDTH(32)) bus ();

    dsp_adder_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.dsp_out = bus.dsp_addsub ? (bus.dsp_in1 - bus.dsp_in2) : (bus.dsp_in1 + bus.dsp_in2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive_pins();
        bus.req0    = pend[0];
        bus.a0      = pa[0];
        bus.b0      = pb[0];
        bus.addsub0 = ps[0];
        bus.req1    = pend[1];
        bus.a1      = pa[1];
        bus.b1      = pb[1];
        bus.addsub1 = ps[1];
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_op(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
        pend[w] = 1'b1;
        ps[w]   = s;
        pa[w]   = a;
        pb[w]   = b;
    endtask

    task automatic rand_op(input int w);
        logic [31:0] a;
        a = pick_val();
        set_op(w, 1'($urandom % 2), a, ($urandom % 5 == 0) ? a : pick_val());
    endtask

    // One arbitration slot: grant cycle, ISSUE, DONE; returns in the next IDLE cycle
    task automatic run_round(input bit rereq);
        int          w;
        exp_t        e;
        logic [31:0] r;
        drive_pins();
        if (!pend[0] && !pend[1]) begin
            @(posedge clk); #1;
            return;
        end
        if (pend[0] && pend[1]) begin
`ifdef DSP_ARB_FIXED_PRIORITY_EN
            w = 0;
`else
            w = (last == 0) ? 1 : 0;
`endif
        end else begin
            w = pend[0] ? 0 : 1;
        end
        last = w;
        r = ps[w] ? (pa[w] - pb[w]) : (pa[w] + pb[w]);
        e.owner = (w == 1);
        e.res   = r;
        e.cyc   = cyc + 2;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (w == 0) begin
            bus.a0 = $urandom; bus.b0 = $urandom; bus.addsub0 = ~bus.addsub0;
        end else begin
            bus.a1 = 32'h1; bus.b1 = $urandom; bus.addsub1 = ~bus.addsub1;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        pend[w] = 1'b0;
        if (rereq) rand_op(w);
        drive_pins();
    endtask

    initial begin
        reset = 1'b1; zero_chk = 1'b0; skip_busy = 1'b0; done = 1'b0; last = 1;
        pend[0] = 0; pend[1] = 0; pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0; ps[0] = 0; ps[1] = 0;
        drive_pins();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; zero_chk = 1'b1;
        @(posedge clk); #1 zero_chk = 1'b0;

        set_op(0, 1'b0, 32'h5, 32'h3);          run_round(1'b0);
        set_op(1, 1'b1, 32'h7, 32'h7);          run_round(1'b0);
        rand_op(0); rand_op(1);
        repeat (4) run_round(1'b1);
        pend[0] = 0; pend[1] = 0;
        while (exp_q.size() > 0) begin @(posedge clk); #1; end
        set_op(0, 1'b0, 32'hFFFF_FFFF, 32'h1);  run_round(1'b0);
        set_op(0, 1'b1, 32'h0, 32'h1);          run_round(1'b0);

        set_op(0, 1'b0, 32'h1234, 32'h1);
        drive_pins();
        @(posedge clk); #1;
        reset = 1'b1; skip_busy = 1'b1; pend[0] = 0; drive_pins();
        @(posedge clk); #1;
        reset = 1'b0; skip_busy = 1'b0; zero_chk = 1'b1; last = 1;
        @(posedge clk); #1 zero_chk = 1'b0;

        set_op(0, 1'b0, 32'h10, 32'h20); set_op(1, 1'b0, 32'h30, 32'h40);
        run_round(1'b0);
        run_round(1'b0);

        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < 2; k++)
                if (!pend[k] && ($urandom % 2 == 0)) rand_op(k);
            run_round(1'($urandom % 2));
        end
        pend[0] = 0; pend[1] = 0; drive_pins();
        repeat (4) @(posedge clk);
        #1 done = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        exp_t e;
        errors = 0;
        checks = 0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            if (zero_chk) begin
                chk("zero_ack0", 32'(bus.ack0), 0);
                chk("zero_ack1", 32'(bus.ack1), 0);
                chk("zero_result", bus.result, 0);
                chk("zero_result_zero", 32'(bus.result_zero), 0);
                chk("zero_dsp_in1", bus.dsp_in1, 0);
                chk("zero_dsp_in2", bus.dsp_in2, 0);
                chk("zero_dsp_addsub", 32'(bus.dsp_addsub), 0);
            end
            if (!skip_busy && !reset)
                chk("busy", 32'(bus.busy),
                    32'((exp_q.size() > 0) && (exp_q[0].cyc - cyc >= 0) && (exp_q[0].cyc - cyc <= 1)));
            if (bus.ack0 || bus.ack1) begin
                chk("ack_onehot", 32'(bus.ack0 && bus.ack1), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_owner", 32'(bus.ack1), 32'(e.owner));
                    chk("ack_cycle", cyc, e.cyc);
                    chk("result", bus.result, e.res);
                    chk("result_zero", 32'(bus.result_zero), 32'(e.res == 0));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_ack", 0, 1);
            end
            if (done) begin
                chk("queue_empty", exp_q.size(), 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            if (cyc > 60000) begin
                chk("timeout", 1, 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end
endmodule

// File: doc/dsp_adder_arbiter.md
Name: dsp_adder_arbiter

Overview:
- Sequences the single shared SB_MAC16-based `adder_dsp` add/sub instance between two requesters.
- Requester 0 is the ALU add/sub path. Requester 1 is the auxiliary address/branch-target adder path.
- Latches the winning operands and drives the DSP inputs from registers. Captures the DSP result and returns it with a one-cycle acknowledge pulse to the owning requester.
- Sits between the requesters and the `adder_dsp` instance. The DSP itself stays combinational from this block's point of view.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 operation request; held high until ack0.
- addsub0  input  1  requester 0 op: 0 = add (a0+b0), 1 = subtract (a0-b0).
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 operation request; held high until ack1.
- addsub1  input  1  requester 1 op select; same encoding as addsub0.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- ack0  output  1  one-cycle pulse: result valid for requester 0.
- ack1  output  1  one-cycle pulse: result valid for requester 1.
- result  output  WIDTH  registered result, valid while ackN high.
- result_zero  output  1  registered (result == 0), valid with ackN.
- busy  output  1  high in ISSUE and DONE states.
- dsp_in1  output  WIDTH  registered operand A to the DSP.
- dsp_in2  output  WIDTH  registered operand B to the DSP.
- dsp_addsub  output  1  registered op select to the DSP.
- dsp_out  input  WIDTH  DSP combinational result.

Behaviour:
- Reset:
  - All outputs, including dsp_in1, dsp_in2 and dsp_addsub, are 0.
  - state = IDLE; owner = 0; last_grant = 1, so requester 0 wins the first tie.
- States: IDLE, ISSUE, DONE. Encoding is free.
- IDLE:
  - No req: stay in IDLE.
  - Any req: pick a winner (arbitration rules below) and latch its a/b/addsub into dsp_in1/dsp_in2/dsp_addsub. Set owner = winner, last_grant = winner, and go to ISSUE.
- ISSUE:
  - The DSP inputs are stable for the whole cycle.
  - At the edge: result <= dsp_out; result_zero <= (dsp_out == 0); ack[owner] <= 1; go to DONE.
- DONE:
  - ack[owner] is high for exactly this cycle; the other ack stays 0.
  - At the edge: ack <= 0 and go to IDLE. dsp_in*, result and result_zero hold their values.
- Requests are sampled only in IDLE.
  - A req still high during DONE is ignored.
  - A req high in the following IDLE cycle is treated as a new operation.
  - Requesters drop or update req and operands at the DONE edge.
- Latency and throughput:
  - req high in IDLE cycle N gives ack high in cycle N+2.
  - Maximum throughput is one operation per 3 cycles.
- Operand sampling: operands are sampled only in the IDLE grant cycle. Changes in ISSUE or DONE do not affect the in-flight result.
- Arithmetic:
  - Result is modulo 2^WIDTH. No carry or overflow output.
  - Subtract is A minus B.
- Arbitration when both req0 and req1 are high in IDLE: grant the requester != last_grant (round robin).
- Single request: granted immediately, regardless of last_grant.
- Reset asserted in ISSUE or DONE:
  - Return to IDLE next edge.
  - No ack is issued for the aborted operation.
  - last_grant returns to 1.
- result and result_zero hold their last values outside DONE. Consumers qualify them with ackN.

Optional Feature:
- Macro: DSP_ARB_FIXED_PRIORITY_EN.
- Defined: ties always go to requester 0 and last_grant is not used. Requester 1 can starve while req0 is continuously reasserted.
- Undefined: round-robin arbitration as described in Behaviour.

Test Plan:
- Reset, then req0=1, addsub0=0, a0=32'h00000005, b0=32'h00000003 in IDLE cycle N -> ack0=1 in cycle N+2, result=32'h00000008, result_zero=0, ack1=0, busy high in N+1..N+2.
- req1 only, addsub1=1, a1=32'h00000007, b1=32'h00000007 -> ack1 at N+2, result=0, result_zero=1; a1 changed to 32'h1 during ISSUE -> result still 0.
- req0 and req1 held high continuously:
  - Round robin: ack order 0,1,0,1, each 3 cycles apart.
  - With DSP_ARB_FIXED_PRIORITY_EN: ack0 every 3 cycles, ack1 never.
- Wrap-around: a0=32'hFFFFFFFF + b0=32'h1 -> result=0, result_zero=1. a0=0 - b0=1 -> result=32'hFFFFFFFF.
- reset pulsed during ISSUE of a req0 operation -> no ack0; next cycle state IDLE with all outputs 0; subsequent tie grants requester 0.
- req0 kept high through DONE -> a second operation starts in the next IDLE cycle; second ack0 exactly 3 cycles after the first.
